// File: rtl/pipe_reg_if_id_skid.sv
// IF/ID pipeline register with a valid/ready handshake, 2-entry skid buffer,
// hazard stall, branch flush with NOP insertion and saturating event counters.
module pipe_reg_if_id_skid #(
    parameter int unsigned          PC_W      = 32,
    parameter int unsigned          INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc4,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc4,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

    state_t             state, state_nxt;
    logic [PC_W-1:0]    skid_pc4, skid_pc4_nxt, main_pc4_nxt;
    logic [INSTR_W-1:0] skid_instr, skid_instr_nxt, main_instr_nxt;
    logic               in_fire, acc;

    assign in_fire = in_valid & in_ready;
    assign acc     = out_valid & out_ready & ~stall;

    always_comb begin
        state_nxt      = state;
        main_pc4_nxt   = out_pc4;
        main_instr_nxt = out_instr;
        skid_pc4_nxt   = skid_pc4;
        skid_instr_nxt = skid_instr;

        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt      = HALF;
                    main_pc4_nxt   = in_pc4;
                    main_instr_nxt = in_instr;
                end
            end
            HALF: begin
                if (in_fire && acc) begin
                    main_pc4_nxt   = in_pc4;
                    main_instr_nxt = in_instr;
                end else if (in_fire) begin
                    state_nxt      = FULL;
                    skid_pc4_nxt   = in_pc4;
                    skid_instr_nxt = in_instr;
                end else if (acc) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (acc) begin
                    state_nxt      = HALF;
                    main_pc4_nxt   = skid_pc4;
                    main_instr_nxt = skid_instr;
                end
            end
            default: state_nxt = EMPTY;
        endcase

        // Flush overrides every transition above, including a same-cycle in_fire.
        if (flush) begin
            state_nxt      = EMPTY;
            skid_pc4_nxt   = '0;
            skid_instr_nxt = NOP_INSTR;
        end

        if (state_nxt == EMPTY) begin
            main_pc4_nxt   = '0;
            main_instr_nxt = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_pc4    <= '0;
            out_instr  <= NOP_INSTR;
            skid_pc4   <= '0;
            skid_instr <= NOP_INSTR;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            in_ready   <= (state_nxt != FULL);
            out_valid  <= (state_nxt != EMPTY);
            out_pc4    <= main_pc4_nxt;
            out_instr  <= main_instr_nxt;
            skid_pc4   <= skid_pc4_nxt;
            skid_instr <= skid_instr_nxt;
            if (out_valid && stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_reg_if_id_skid.sv
// Randomized + directed bench for pipe_reg_if_id_skid against a FIFO-queue
// reference model of the IF/ID skid register.
module tb_pipe_reg_if_id_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          CMAX = 15;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, stall, flush, out_valid, out_ready;
    logic [31:0] in_pc4, in_instr, out_pc4, out_instr;
    logic [3:0]  stall_cnt, flush_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: up to two entries in order of acceptance.
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    logic        m_ready = 1'b1;
    int          m_scnt  = 0;
    int          m_fcnt  = 0;

    pipe_reg_if_id_skid #(
        .PC_W      (32),
        .INSTR_W   (32),
        .NOP_INSTR (NOP),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc4    (in_pc4),
        .in_instr  (in_instr),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc4   (out_pc4),
        .out_instr (out_instr),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        bit fire, acc;
        if (rst) begin
            q_pc.delete();
            q_in.delete();
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            fire = in_valid && m_ready;
            acc  = (q_pc.size() > 0) && out_ready && !stall;
            if ((q_pc.size() > 0) && stall && m_scnt < CMAX) m_scnt++;
            if (flush && m_fcnt < CMAX) m_fcnt++;
            if (flush) begin
                q_pc.delete();
                q_in.delete();
            end else begin
                if (acc) begin
                    void'(q_pc.pop_front());
                    void'(q_in.pop_front());
                end
                if (fire) begin
                    q_pc.push_back(in_pc4);
                    q_in.push_back(in_instr);
                end
            end
        end
        m_ready = (q_pc.size() < 2);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        check("out_valid", 64'(out_valid), 64'(q_pc.size() > 0));
        check("in_ready",  64'(in_ready),  64'(m_ready));
        check("out_pc4",   64'(out_pc4),   (q_pc.size() > 0) ? 64'(q_pc[0]) : 64'd0);
        check("out_instr", 64'(out_instr), (q_in.size() > 0) ? 64'(q_in[0]) : 64'(NOP));
        check("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
        check("flush_cnt", 64'(flush_cnt), 64'(m_fcnt));
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic st, input logic fl, input logic ordy);
        in_valid  = v;
        in_pc4    = pc;
        in_instr  = ins;
        stall     = st;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Reset state
        do_reset();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_instr", 64'(out_instr), 64'(NOP));
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_cnts",  64'({stall_cnt, flush_cnt}), 64'd0);

        // Streaming, one per cycle
        drive(1'b1, 32'h4, 32'h8C01_0000, 1'b0, 1'b0, 1'b1);
        cyc();
        check("t2_pc4",   64'(out_pc4), 64'h4);
        check("t2_instr", 64'(out_instr), 64'h8C01_0000);
        drive(1'b1, 32'h8, 32'h1111_0008, 1'b0, 1'b0, 1'b1);
        cyc();
        check("t2_pc8", 64'(out_pc4), 64'h8);
        drive(1'b1, 32'hC, 32'h1111_000C, 1'b0, 1'b0, 1'b1);
        cyc();
        check("t2_pcC", 64'(out_pc4), 64'hC);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cyc();

        // Backpressure fills the skid
        drive(1'b1, 32'h4, 32'hAAAA_0004, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h8, 32'hAAAA_0008, 1'b0, 1'b0, 1'b0);
        cyc();
        check("t3_full_ready", 64'(in_ready), 64'd0);
        check("t3_head", 64'(out_pc4), 64'h4);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cyc();
        check("t3_second", 64'(out_pc4), 64'h8);
        check("t3_ready_back", 64'(in_ready), 64'd1);
        cyc();

        // Stall holds the entry and counts
        do_reset();
        drive(1'b1, 32'h20, 32'hBBBB_0020, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        repeat (3) cyc();
        check("t4_hold", 64'(out_pc4), 64'h20);
        check("t4_scnt", 64'(stall_cnt), 64'd3);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cyc();

        // Flush from FULL drops everything including the incoming entry
        do_reset();
        drive(1'b1, 32'h30, 32'hCCCC_0030, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h34, 32'hCCCC_0034, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h99, 32'hDEAD_0099, 1'b0, 1'b1, 1'b0);
        cyc();
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_nop",   64'(out_instr), 64'(NOP));
        check("t5_ready", 64'(in_ready), 64'd1);
        check("t5_fcnt",  64'(flush_cnt), 64'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        repeat (3) cyc();

        // Saturating stall counter, then reset while FULL
        drive(1'b1, 32'h40, 32'hEEEE_0040, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        repeat (20) cyc();
        check("t6_sat", 64'(stall_cnt), 64'd15);
        drive(1'b1, 32'h44, 32'hEEEE_0044, 1'b1, 1'b0, 1'b0);
        cyc();
        check("t6_full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_ready", 64'(in_ready), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 9) < 7, $urandom, $urandom,
                  $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
